// File: rtl/mem_arbiter.sv
// Two-client (instruction fetch / data) arbiter onto a single memory port, one transaction at a time.
// Optional round-robin tie-breaking is enabled by defining MEM_ARBITER_RR_EN; otherwise data has fixed priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // instruction-fetch client
  input  logic                    i_read,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_resp,
  // data client
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  input  logic [ADDR_WIDTH-1:0]   d_address,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_resp,
  // downstream memory
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic [DATA_WIDTH/8-1:0] pmem_wmask,
  output logic [ADDR_WIDTH-1:0]   pmem_address,
  output logic [DATA_WIDTH-1:0]   pmem_wdata,
  input  logic [DATA_WIDTH-1:0]   pmem_rdata,
  input  logic                    pmem_resp,
  // debug view of the FSM state (0 IDLE, 1 BUSY, 2 RESP)
  output logic [1:0]              o_dbg_state
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  // Handshake: a client holds its request until its one-cycle resp pulse and drops
  // it the next cycle; memory holds pmem_read/pmem_write until one pmem_resp cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                  w_d_req;
  logic                  w_i_req;
  logic                  w_grant_d;
  logic                  w_start;
  logic                  w_done;

  logic                  r_client_d;
  logic                  r_pmem_read;
  logic                  r_pmem_write;
  logic [MASK_WIDTH-1:0] r_pmem_wmask;
  logic [ADDR_WIDTH-1:0] r_pmem_address;
  logic [DATA_WIDTH-1:0] r_pmem_wdata;
  logic [DATA_WIDTH-1:0] r_i_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;
  logic                  r_i_resp;
  logic                  r_d_resp;

  assign w_d_req = d_read | d_write;
  assign w_i_req = i_read;
  assign w_start = (r_state == ST_IDLE) && (w_d_req || w_i_req);
  assign w_done  = (r_state == ST_BUSY) && pmem_resp;

`ifdef MEM_ARBITER_RR_EN
  // 1 = data client was granted last; reset value favours data on the first tie
  logic r_last_d;

  assign w_grant_d = w_d_req && (!w_i_req || !r_last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b0;
    end else if (w_start) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  assign w_grant_d = w_d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_next = ST_BUSY;
      ST_BUSY: if (w_done)  w_state_next = ST_RESP;
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_client_d     <= 1'b0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_wmask   <= '0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
      r_i_rdata      <= '0;
      r_d_rdata      <= '0;
      r_i_resp       <= 1'b0;
      r_d_resp       <= 1'b0;
    end else begin
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;
      if (w_start) begin
        r_client_d <= w_grant_d;
        if (w_grant_d) begin
          // a simultaneous read and write from the data client is a write
          r_pmem_write   <= d_write;
          r_pmem_read    <= !d_write;
          r_pmem_address <= d_address;
          r_pmem_wmask   <= d_wmask;
          r_pmem_wdata   <= d_write ? d_wdata : '0;
        end else begin
          r_pmem_write   <= 1'b0;
          r_pmem_read    <= 1'b1;
          r_pmem_address <= i_address;
          r_pmem_wmask   <= '1;
          r_pmem_wdata   <= '0;
        end
      end
      if (w_done) begin
        r_pmem_read  <= 1'b0;
        r_pmem_write <= 1'b0;
        if (r_client_d) begin
          r_d_rdata <= pmem_rdata;
          r_d_resp  <= 1'b1;
        end else begin
          r_i_rdata <= pmem_rdata;
          r_i_resp  <= 1'b1;
        end
      end
    end
  end

  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_wmask   = r_pmem_wmask;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;
  assign i_rdata      = r_i_rdata;
  assign d_rdata      = r_d_rdata;
  assign i_resp       = r_i_resp;
  assign d_resp       = r_d_resp;
  assign o_dbg_state  = r_state;

endmodule
